// File: rtl/data_bus_pkg.sv
// Shared encodings and the access-error check for the data-memory responder.
package data_bus_pkg;

   localparam logic [1:0] SIZE_BYTE = 2'b00;
   localparam logic [1:0] SIZE_HALF = 2'b01;
   localparam logic [1:0] SIZE_WORD = 2'b10;

   localparam int CNT_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT   = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } bus_state_e;

   // Misalignment and illegal size are judged from the low address bits;
   // the range check needs DEPTH, so the caller supplies it.
   function automatic logic access_error(input logic [1:0] size,
                                         input logic [1:0] offset,
                                         input logic       out_of_range);
      logic err;
      err = out_of_range;
      case (size)
         SIZE_BYTE: err = out_of_range;
         SIZE_HALF: if (offset[0]) err = 1'b1;
         SIZE_WORD: if (offset != 2'b00) err = 1'b1;
         default:   err = 1'b1;
      endcase
      return err;
   endfunction

endpackage

// File: rtl/load_store_align.sv
// Byte-lane merge for sub-word stores and lane extract/extend for loads.
module load_store_align
   import data_bus_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] old_word_i,
   input  logic [XLEN-1:0] store_data_i,
   input  logic [1:0]      size_i,
   input  logic [1:0]      offset_i,
   input  logic            unsigned_i,
   output logic [XLEN-1:0] merged_o,
   output logic [XLEN-1:0] load_o
);

   logic [4:0]      shift;
   logic [XLEN-1:0] lane_mask;
   logic [XLEN-1:0] shifted_word;

   // Half offsets are already known even (odd ones are errors), so one shift serves all sizes.
   assign shift        = {offset_i, 3'b000};
   assign shifted_word = old_word_i >> shift;

   always_comb begin
      lane_mask = '0;
      case (size_i)
         SIZE_BYTE: lane_mask = {{(XLEN-8){1'b0}}, 8'hFF};
         SIZE_HALF: lane_mask = {{(XLEN-16){1'b0}}, 16'hFFFF};
         default:   lane_mask = '1;
      endcase
   end

   assign merged_o = (old_word_i & ~(lane_mask << shift))
                   | ((store_data_i & lane_mask) << shift);

   always_comb begin
      load_o = old_word_i;
      case (size_i)
         SIZE_BYTE: load_o = {{(XLEN-8){shifted_word[7] & ~unsigned_i}}, shifted_word[7:0]};
         SIZE_HALF: load_o = {{(XLEN-16){shifted_word[15] & ~unsigned_i}}, shifted_word[15:0]};
         default:   load_o = old_word_i;
      endcase
   end

endmodule

// File: rtl/data_bus_responder.sv
// Data-memory responder: valid/ready request/response around a word RAM with
// configurable wait states, RV32I access sizes and error responses.
module data_bus_responder
   import data_bus_pkg::*;
#(
   parameter int XLEN        = 32,
   parameter int DEPTH       = 128,
   parameter int WAIT_CYCLES = 2
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic            req_write,
   input  logic [1:0]      req_size,
   input  logic            req_unsigned,
   input  logic [XLEN-1:0] req_address,
   input  logic [XLEN-1:0] req_write_data,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_read_data,
   output logic            resp_error
);

   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [CNT_W-1:0] CNT_INIT =
      (WAIT_CYCLES == 0) ? '0 : CNT_W'(WAIT_CYCLES - 1);

   bus_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             capture;

   logic             write_q;
   logic [1:0]       size_q;
   logic             unsigned_q;
   logic [XLEN-1:0]  addr_q;
   logic [XLEN-1:0]  wdata_q;

   logic             req_ready_q, resp_valid_q, resp_error_q;
   logic [XLEN-1:0]  resp_read_data_q, resp_read_data_d;
   logic             resp_error_d;

   logic [XLEN-1:0]  mem_q [DEPTH];
   logic [IDX_W-1:0] ram_idx;
   logic             out_of_range;
   logic             store_en;
   logic [XLEN-1:0]  old_word, merged_word, load_word;

   assign ram_idx      = addr_q[IDX_W+1:2];
   assign out_of_range = addr_q[XLEN-1:2] >= (XLEN-2)'(DEPTH);
   assign old_word     = out_of_range ? '0 : mem_q[ram_idx];

   load_store_align #(.XLEN(XLEN)) u_align (
      .old_word_i   (old_word),
      .store_data_i (wdata_q),
      .size_i       (size_q),
      .offset_i     (addr_q[1:0]),
      .unsigned_i   (unsigned_q),
      .merged_o     (merged_word),
      .load_o       (load_word)
   );

   always_comb begin
      state_d          = state_q;
      cnt_d            = cnt_q;
      capture          = 1'b0;
      store_en         = 1'b0;
      resp_error_d     = access_error(size_q, addr_q[1:0], out_of_range);
      resp_read_data_d = (write_q || resp_error_d) ? '0 : load_word;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               capture = 1'b1;
               if (WAIT_CYCLES == 0) begin
                  state_d = ACCESS;
               end else begin
                  state_d = WAIT;
                  cnt_d   = CNT_INIT;
               end
            end
         end
         WAIT: begin
            if (cnt_q == '0) state_d = ACCESS;
            else             cnt_d   = cnt_q - 1'b1;
         end
         ACCESS: begin
            store_en = write_q && !resp_error_d;
            state_d  = RESP;
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Control, response registers and RAM; reset drops any in-flight access.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q          <= IDLE;
         cnt_q            <= '0;
         req_ready_q      <= 1'b1;
         resp_valid_q     <= 1'b0;
         resp_read_data_q <= '0;
         resp_error_q     <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         req_ready_q  <= (state_d == IDLE);
         resp_valid_q <= (state_d == RESP);
         if (state_q == ACCESS) begin
            resp_read_data_q <= resp_read_data_d;
            resp_error_q     <= resp_error_d;
         end
         if (store_en) mem_q[ram_idx] <= merged_word;
      end
   end

   // Request capture; only meaningful once the FSM has accepted.
   always_ff @(posedge clock) begin
      if (capture) begin
         write_q    <= req_write;
         size_q     <= req_size;
         unsigned_q <= req_unsigned;
         addr_q     <= req_address;
         wdata_q    <= req_write_data;
      end
   end

   assign req_ready      = req_ready_q;
   assign resp_valid     = resp_valid_q;
   assign resp_read_data = resp_read_data_q;
   assign resp_error     = resp_error_q;

endmodule

// File: tb/tb_data_bus_responder.sv
// Scoreboard bench for data_bus_responder: a WAIT_CYCLES=2 instance for the
// main scenarios and a WAIT_CYCLES=0 instance for minimum latency/throughput.
module tb_data_bus_responder;

   localparam int XLEN  = 32;
   localparam int DEPTH = 128;
   localparam int WAITC = 2;

   typedef struct packed {
      logic [XLEN-1:0] data;
      logic            err;
   } exp_t;

   logic            clock = 1'b0;
   logic            reset = 1'b1;
   logic            req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0;
   logic [1:0]      req_size = 2'b10;
   logic [XLEN-1:0] req_address = '0, req_write_data = '0;
   logic            resp_ready = 1'b0;
   logic            req_ready, resp_valid, resp_error;
   logic [XLEN-1:0] resp_read_data;

   logic            z_req_valid = 1'b0, z_req_write = 1'b0, z_req_unsigned = 1'b0;
   logic [1:0]      z_req_size = 2'b10;
   logic [XLEN-1:0] z_req_address = '0, z_req_write_data = '0;
   logic            z_resp_ready = 1'b0;
   logic            z_req_ready, z_resp_valid, z_resp_error;
   logic [XLEN-1:0] z_resp_read_data;

   int   errors = 0;
   int   checks = 0;
   exp_t sb_q[$];

   always #5 clock = ~clock;

   data_bus_responder #(.XLEN(XLEN), .DEPTH(DEPTH), .WAIT_CYCLES(WAITC)) dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_address(req_address),
      .req_write_data(req_write_data),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_read_data(resp_read_data), .resp_error(resp_error)
   );

   data_bus_responder #(.XLEN(XLEN), .DEPTH(DEPTH), .WAIT_CYCLES(0)) dut0 (
      .clock(clock), .reset(reset),
      .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
      .req_size(z_req_size), .req_unsigned(z_req_unsigned), .req_address(z_req_address),
      .req_write_data(z_req_write_data),
      .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
      .resp_read_data(z_resp_read_data), .resp_error(z_resp_error)
   );

   task automatic do_req(input string nm, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [XLEN-1:0] addr,
                         input logic [XLEN-1:0] wdata, input logic [XLEN-1:0] exp_data,
                         input logic exp_err, input int hold);
      int   cyc;
      exp_t e;
      @(negedge clock);
      checks++;
      if (req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s req_ready before accept: got %b want 1", nm, req_ready);
      end
      req_valid = 1'b1; req_write = wr; req_size = sz; req_unsigned = uns;
      req_address = addr; req_write_data = wdata;
      sb_q.push_back('{data: exp_data, err: exp_err});
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0; req_write = 1'($urandom); req_size = 2'($urandom);
      req_unsigned = 1'($urandom); req_address = $urandom; req_write_data = $urandom;
      cyc = 0;
      while (resp_valid !== 1'b1 && cyc < 40) begin
         @(posedge clock);
         cyc++;
         @(negedge clock);
      end
      checks++;
      if (cyc != WAITC + 1) begin
         errors++;
         $display("FAIL %s latency: got %0d edges want %0d", nm, cyc, WAITC + 1);
      end
      if (resp_valid === 1'b1 && sb_q.size() > 0) begin
         e = sb_q.pop_front();
         checks++;
         if (resp_read_data !== e.data) begin
            errors++;
            $display("FAIL %s data: got %h want %h", nm, resp_read_data, e.data);
         end
         checks++;
         if (resp_error !== e.err) begin
            errors++;
            $display("FAIL %s error: got %b want %b", nm, resp_error, e.err);
         end
         for (int i = 0; i < hold; i++) begin
            @(posedge clock);
            @(negedge clock);
            checks++;
            if (resp_valid !== 1'b1 || resp_read_data !== e.data || resp_error !== e.err
                || req_ready !== 1'b0) begin
               errors++;
               $display("FAIL %s hold cycle %0d: got v=%b d=%h e=%b rr=%b want v=1 d=%h e=%b rr=0",
                        nm, i, resp_valid, resp_read_data, resp_error, req_ready, e.data, e.err);
            end
         end
      end else begin
         void'(sb_q.pop_front());
      end
      resp_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      resp_ready = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s release: got v=%b rr=%b want v=0 rr=1", nm, resp_valid, req_ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      repeat (2) @(posedge clock);
      @(negedge clock);
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_read_data !== '0 || resp_error !== 1'b0) begin
         errors++;
         $display("FAIL reset_main: got rr=%b v=%b d=%h e=%b want 1 0 0 0",
                  req_ready, resp_valid, resp_read_data, resp_error);
      end
      checks++;
      if (z_req_ready !== 1'b1 || z_resp_valid !== 1'b0 || z_resp_read_data !== '0 || z_resp_error !== 1'b0) begin
         errors++;
         $display("FAIL reset_zero: got rr=%b v=%b d=%h e=%b want 1 0 0 0",
                  z_req_ready, z_resp_valid, z_resp_read_data, z_resp_error);
      end
      reset = 1'b0;
   endtask

   task automatic test_word_roundtrip();
      do_req("sw_10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
      do_req("lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
      do_req("sw_top", 1'b1, 2'b10, 1'b0, 32'(4*(DEPTH-1)), 32'h0BADF00D, 32'h0, 1'b0, 0);
      do_req("lw_top", 1'b0, 2'b10, 1'b0, 32'(4*(DEPTH-1)), 32'h0, 32'h0BADF00D, 1'b0, 0);
   endtask

   task automatic test_extension();
      do_req("sw_20", 1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 32'h0, 1'b0, 0);
      do_req("sb_22", 1'b1, 2'b00, 1'b0, 32'h22, 32'h12345680, 32'h0, 1'b0, 0);
      do_req("lb_22", 1'b0, 2'b00, 1'b0, 32'h22, 32'h0, 32'hFFFFFF80, 1'b0, 0);
      do_req("lbu_22", 1'b0, 2'b00, 1'b1, 32'h22, 32'h0, 32'h00000080, 1'b0, 0);
      do_req("lw_20a", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h00800000, 1'b0, 0);
      do_req("sh_20", 1'b1, 2'b01, 1'b0, 32'h20, 32'hABCD8001, 32'h0, 1'b0, 0);
      do_req("lh_20", 1'b0, 2'b01, 1'b0, 32'h20, 32'h0, 32'hFFFF8001, 1'b0, 0);
      do_req("lhu_20", 1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'h00008001, 1'b0, 0);
      do_req("lw_20b", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h00808001, 1'b0, 0);
   endtask

   task automatic test_errors();
      do_req("lh_21", 1'b0, 2'b01, 1'b0, 32'h21, 32'h0, 32'h0, 1'b1, 0);
      do_req("sw_22", 1'b1, 2'b10, 1'b0, 32'h22, 32'hFFFFFFFF, 32'h0, 1'b1, 0);
      do_req("lw_20c", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h00808001, 1'b0, 0);
      do_req("lw_oob", 1'b0, 2'b10, 1'b0, 32'(4*DEPTH), 32'h0, 32'h0, 1'b1, 0);
      do_req("size11", 1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 32'h0, 1'b1, 0);
   endtask

   task automatic test_backpressure();
      do_req("bp_lw_10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 5);
   endtask

   task automatic test_reset_mid_access();
      @(negedge clock);
      req_valid = 1'b1; req_write = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
      req_address = 32'h30; req_write_data = 32'h12345678;
      @(posedge clock);
      @(negedge clock);
      req_valid = 1'b0;
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_read_data !== '0 || resp_error !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset outputs: got rr=%b v=%b d=%h e=%b want 1 0 0 0",
                  req_ready, resp_valid, resp_read_data, resp_error);
      end
      repeat (WAITC + 3) @(posedge clock);
      @(negedge clock);
      checks++;
      if (resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL mid_reset stray response: got v=%b want 0", resp_valid);
      end
      do_req("lw_30", 1'b0, 2'b10, 1'b0, 32'h30, 32'h0, 32'h0, 1'b0, 0);
      do_req("lw_10_cleared", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h0, 1'b0, 0);
   endtask

   task automatic test_zero_wait_back_to_back();
      @(negedge clock);
      checks++;
      if (z_req_ready !== 1'b1) begin
         errors++;
         $display("FAIL z_ready_first: got %b want 1", z_req_ready);
      end
      z_req_valid = 1'b1; z_req_write = 1'b1; z_req_size = 2'b10;
      z_req_address = 32'h8; z_req_write_data = 32'hCAFEF00D; z_resp_ready = 1'b1;
      @(posedge clock);
      @(negedge clock);
      z_req_write = 1'b0; z_req_write_data = 32'h0;
      checks++;
      if (z_resp_valid !== 1'b0 || z_req_ready !== 1'b0) begin
         errors++;
         $display("FAIL z_t0: got v=%b rr=%b want 0 0", z_resp_valid, z_req_ready);
      end
      @(posedge clock);
      @(negedge clock);
      checks++;
      if (z_resp_valid !== 1'b1 || z_resp_read_data !== '0 || z_resp_error !== 1'b0) begin
         errors++;
         $display("FAIL z_store_resp: got v=%b d=%h e=%b want 1 0 0",
                  z_resp_valid, z_resp_read_data, z_resp_error);
      end
      @(posedge clock);
      @(negedge clock);
      checks++;
      if (z_req_ready !== 1'b1 || z_resp_valid !== 1'b0) begin
         errors++;
         $display("FAIL z_idle_again: got rr=%b v=%b want 1 0", z_req_ready, z_resp_valid);
      end
      @(posedge clock);
      @(negedge clock);
      z_req_valid = 1'b0;
      @(posedge clock);
      @(negedge clock);
      checks++;
      if (z_resp_valid !== 1'b1 || z_resp_read_data !== 32'hCAFEF00D || z_resp_error !== 1'b0) begin
         errors++;
         $display("FAIL z_load_resp: got v=%b d=%h e=%b want 1 cafef00d 0",
                  z_resp_valid, z_resp_read_data, z_resp_error);
      end
      @(posedge clock);
      @(negedge clock);
      z_resp_ready = 1'b0;
   endtask

   initial begin
      test_reset();
      test_word_roundtrip();
      test_extension();
      test_errors();
      test_backpressure();
      test_reset_mid_access();
      test_zero_wait_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/data_bus_responder.md
Name: data_bus_responder

Overview:
- Memory-side responder for the core's data-memory interface, adding a valid/ready request/response handshake and a configurable wait-state latency.
- Holds a word-organised RAM and supports the RV32I access sizes: byte, halfword and word stores, and signed or unsigned byte/halfword loads.
- Flags misaligned and out-of-range accesses with an error response instead of corrupting memory.
- Sits between the load/store path and the RAM, replacing the zero-latency data memory in multi-cycle configurations.

Parameters:
- XLEN, 32: data and address width.
- DEPTH, 128: number of XLEN-bit words stored.
- WAIT_CYCLES, 2: extra cycles between request accept and response; legal range 0..15.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  00 byte, 01 half, 10 word, 11 illegal.
- req_unsigned  input  1  zero-extend load (LBU/LHU); ignored for stores and word loads.
- req_address  input  XLEN  byte address.
- req_write_data  input  XLEN  store data, right-aligned (byte in [7:0], half in [15:0]).
- resp_valid  output  1  response present.
- resp_ready  input  1  requester accepts the response.
- resp_read_data  output  XLEN  extended load data; 0 for stores and errors.
- resp_error  output  1  access was misaligned, out of range, or illegal size.

Behaviour:
- Reset (synchronous, active-high):
  - state = IDLE, req_ready = 1, resp_valid = 0, resp_read_data = 0, resp_error = 0, wait counter = 0.
  - All RAM words cleared to 0.
  - Reset wins over any handshake in the same cycle, including mid-WAIT or mid-RESP; a pending access is dropped and any store it carried is not performed.
- States:
  - IDLE: req_ready = 1. On req_valid && req_ready, capture all req_* fields. Go to WAIT with counter = WAIT_CYCLES - 1, or straight to ACCESS when WAIT_CYCLES == 0.
  - WAIT: req_ready = 0. Decrement the counter each cycle; go to ACCESS when it reaches 0.
  - ACCESS: one cycle. Perform the store or read the RAM word, compute the error and extended data, register the outputs, go to RESP.
  - RESP: resp_valid = 1 and outputs stable. On resp_ready, go to IDLE; resp_valid drops the next cycle.
- Latency and throughput:
  - Request accepted at edge T gives resp_valid high after edge T + WAIT_CYCLES + 1.
  - With resp_ready tied high, a new request is accepted every WAIT_CYCLES + 3 cycles.
  - req_ready is 0 in all states other than IDLE, so there is no overlap of accesses.
- Error detection (captured address):
  - half with addr[0] = 1;
  - word with addr[1:0] != 0;
  - size = 11;
  - word index addr[XLEN-1:2] >= DEPTH.
  - On error: no RAM write, resp_read_data = 0, resp_error = 1.
- Stores:
  - Byte lane = addr[1:0] for bytes, addr[1] for halves; only the addressed lanes change.
  - Stores return resp_read_data = 0, resp_error = 0.
- Loads:
  - Extract the lane, then sign-extend, or zero-extend when req_unsigned = 1.
  - Word loads are returned as-is.
- Inputs are sampled only at accept; changes to req_* after accept have no effect.
- resp_ready asserted before resp_valid is ignored.
- All outputs are registered.

Decomposition:
- Shared package data_bus_pkg:
  - SIZE_BYTE = 2'b00, SIZE_HALF = 2'b01, SIZE_WORD = 2'b10;
  - state encoding IDLE/WAIT/ACCESS/RESP;
  - the error-cause check as a function.
- One combinational sub-module, load_store_align. It holds:
  - store lane-merge (old word, data, size, offset → new word);
  - load extract/extend (word, size, offset, unsigned → result).
- The top module holds the FSM, counter, RAM and registers.

Test Plan:
- Word round trip, WAIT_CYCLES = 2: SW 0xDEADBEEF to 0x10, then LW 0x10 → resp_read_data = 0xDEADBEEF, resp_error = 0. resp_valid rises exactly 3 edges after each accept.
- Byte and half extension: SW 0x00000000 to 0x20, SB 0x80 to 0x22, then:
  - LB 0x22 → 0xFFFFFF80;
  - LBU 0x22 → 0x00000080;
  - LW 0x20 → 0x00800000;
  - SH 0x8001 to 0x20, then LH 0x20 → 0xFFFF8001 and LHU 0x20 → 0x00008001.
- Errors:
  - LH 0x21 → error = 1, data = 0;
  - SW 0x22 → error = 1, and LW 0x20 afterwards shows the word unchanged;
  - LW 4*DEPTH → error = 1;
  - req_size = 11 → error = 1.
- Backpressure: hold resp_ready = 0 for 5 cycles after resp_valid → resp_valid, data and error stay stable and req_ready stays 0. Raise resp_ready → IDLE next cycle and req_ready = 1.
- Reset mid-access: accept SW 0x12345678 to 0x30, assert reset during WAIT → all outputs at reset values next edge. A later LW 0x30 → 0x00000000.
- WAIT_CYCLES = 0 instance: LW accepted at edge T → resp_valid high after edge T + 1. A back-to-back second request is accepted 3 cycles after the first with resp_ready held high.
